// File: rtl/icache_direct_pkg.sv
// Shared constants, bus tag and controller state type for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 16;
  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_ADDR_W    = 58;
  localparam int LINE_OFF_W     = $clog2(LINE_BYTES);
  localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);
  localparam int BEAT_W         = $clog2(BEATS_PER_LINE);

  localparam logic [12:0] TAG_READ_MEM = 13'b1_1100_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL
  } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side request/ack signals plus the system-bus request/response channel of the cache.
interface icache_direct_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  import icache_pkg::*;

  logic                      ic_req;
  logic [LINE_ADDR_W-1:0]    ic_line_addr;
  logic [WORD_SEL_W-1:0]     ic_word_select;
  logic                      ic_ack;
  logic [31:0]               ic_data_out;

  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  // Cache side
  modport slave (
    input  ic_req, ic_line_addr, ic_word_select,
    output ic_ack, ic_data_out,
    output bus_reqcyc, bus_req, bus_reqtag,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output bus_respack
  );

  // Fetch stage and bus side
  modport master (
    output ic_req, ic_line_addr, ic_word_select,
    input  ic_ack, ic_data_out,
    input  bus_reqcyc, bus_req, bus_reqtag,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  bus_respack
  );

endinterface

// File: rtl/icache_direct_data_array.sv
// Line storage: NUM_SETS x 16 x 32-bit words, written one 64-bit beat (two words) at a time.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [$clog2(NUM_SETS)-1:0] wr_idx_i,
  input  logic [BEAT_W-1:0]           wr_beat_i,
  input  logic [63:0]                 wr_data_i,
  input  logic [$clog2(NUM_SETS)-1:0] rd_idx_i,
  input  logic [WORD_SEL_W-1:0]       rd_word_i,
  output logic [31:0]                 rd_data_o
);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int DEPTH    = NUM_SETS * BEATS_PER_LINE;

  // Even and odd words live in separate banks so a beat writes both halves at one address.
  logic [31:0] even_q [DEPTH];
  logic [31:0] odd_q  [DEPTH];

  logic [IDX_BITS+BEAT_W-1:0] wr_addr;
  logic [IDX_BITS+BEAT_W-1:0] rd_addr;

  assign wr_addr = {wr_idx_i, wr_beat_i};
  assign rd_addr = {rd_idx_i, rd_word_i[WORD_SEL_W-1:1]};

  always_ff @(posedge clk) begin
    if (we_i) begin
      even_q[wr_addr] <= wr_data_i[31:0];
      odd_q[wr_addr]  <= wr_data_i[63:32];
    end
  end

  assign rd_data_o = rd_word_i[0] ? odd_q[rd_addr] : even_q[rd_addr];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with 8-beat line refill over the system bus.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_direct
  import icache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_SETS       = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  icache_direct_if.slave ic
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_W    = LINE_ADDR_W - IDX_BITS;

  icache_state_t              state_q;
  logic [LINE_ADDR_W-1:0]     req_addr_q;
  logic [WORD_SEL_W-1:0]      req_word_q;
  logic [NUM_SETS-1:0]        valid_q;
  logic [TAG_W-1:0]           tags_q [NUM_SETS];
  logic                       flush_pending_q;
  logic [BEAT_W-1:0]          beat_q;
  logic                       ack_q;
  logic [31:0]                data_q;
  logic                       reqcyc_q;
  logic [BUS_DATA_WIDTH-1:0]  req_q;

  logic [IDX_BITS-1:0]        idx;
  logic [TAG_W-1:0]           tag;
  logic                       hit;
  logic                       accept;
  logic                       beat_fire;
  logic                       last_beat;
  logic [31:0]                rd_word;
  logic [BUS_DATA_WIDTH-1:0]  resp;
  logic                       unused_resptag;

  assign idx       = req_addr_q[IDX_BITS-1:0];
  assign tag       = req_addr_q[LINE_ADDR_W-1:IDX_BITS];
  assign hit       = valid_q[idx] && (tags_q[idx] == tag);
  // ack_q blocks re-accepting the request that is still held high during its own ack cycle.
  assign accept    = (state_q == IDLE) && !flush_pending_q && !flush && ic.ic_req && !ack_q;
  assign beat_fire = (state_q == REFILL) && ic.bus_respcyc;
  assign last_beat = beat_fire && (beat_q == BEAT_W'(BEATS_PER_LINE - 1));
  assign resp      = ic.bus_resp;
  assign unused_resptag = ^ic.bus_resptag;

  icache_data_array #(
    .NUM_SETS (NUM_SETS)
  ) u_data (
    .clk       (clk),
    .we_i      (beat_fire),
    .wr_idx_i  (idx),
    .wr_beat_i (beat_q),
    .wr_data_i (resp[63:0]),
    .rd_idx_i  (idx),
    .rd_word_i (req_word_q),
    .rd_data_o (rd_word)
  );

  assign ic.ic_ack      = ack_q;
  assign ic.ic_data_out = data_q;
  assign ic.bus_reqcyc  = reqcyc_q;
  assign ic.bus_req     = req_q;
  assign ic.bus_reqtag  = BUS_TAG_WIDTH'(TAG_READ_MEM);
  // Beats are consumed everywhere except while the request is still outstanding.
  assign ic.bus_respack = ic.bus_respcyc && !reset && (state_q != MISS_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      beat_q          <= '0;
      ack_q           <= 1'b0;
      data_q          <= '0;
      reqcyc_q        <= 1'b0;
      req_q           <= '0;
    end else begin
      ack_q <= 1'b0;
      if (flush && (state_q != IDLE)) flush_pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flush_pending_q || flush) begin
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
          end else if (accept) begin
            req_addr_q <= ic.ic_line_addr;
            req_word_q <= ic.ic_word_select;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            ack_q   <= 1'b1;
            data_q  <= rd_word;
            state_q <= IDLE;
          end else begin
            reqcyc_q <= 1'b1;
            req_q    <= BUS_DATA_WIDTH'({req_addr_q, {LINE_OFF_W{1'b0}}});
            state_q  <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (ic.bus_reqack) begin
            reqcyc_q <= 1'b0;
            beat_q   <= '0;
            state_q  <= REFILL;
          end
        end
        REFILL: begin
          if (beat_fire) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (last_beat) begin
              valid_q[idx] <= 1'b1;
              state_q      <= LOOKUP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat) tags_q[idx] <= tag;
  end

`ifdef ICACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        from_refill_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The guaranteed hit that follows a refill is not a real hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      from_refill_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      if (last_beat) from_refill_q <= 1'b1;
      else if (accept) from_refill_q <= 1'b0;
      if (state_q == LOOKUP) begin
        if (!hit) miss_cnt_q <= sat_inc(miss_cnt_q);
        else if (!from_refill_q) hit_cnt_q <= sat_inc(hit_cnt_q);
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
